// File: rtl/stage5wb_q_pkg.sv
// stage5wb_q_pkg: shared sizing helpers for the queued write-back stage.
//   entry_width : packed width of one queue entry {pc, instr, result, flags,
//                 waddr, reg_we, lr_we, flag_we}
//   ptr_width   : bits needed to index a DEPTH-entry circular buffer
package stage5wb_q_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 4;
  localparam int FLAG_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  function automatic int entry_width(input int data_w, input int addr_w, input int flag_w);
    return 3 * data_w + flag_w + addr_w + 3;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage5wb_q_if.sv
// stage5wb_q_if: retiring-instruction handshake from the RA stage.
//   master : upstream producer (drives valid_in and the entry fields)
//   slave  : write-back stage (drives ready_out)
interface stage5wb_q_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4,
  parameter int FLAG_W = 4
) ();
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] instr_in;
  logic [DATA_W-1:0] result_in;
  logic [FLAG_W-1:0] flags_in;
  logic [ADDR_W-1:0] reg_waddr_in;
  logic              reg_we_in;
  logic              lr_we_in;
  logic              flag_we_in;

  modport master (
    output valid_in, pc_in, instr_in, result_in, flags_in,
           reg_waddr_in, reg_we_in, lr_we_in, flag_we_in,
    input  ready_out
  );

  modport slave (
    input  valid_in, pc_in, instr_in, result_in, flags_in,
           reg_waddr_in, reg_we_in, lr_we_in, flag_we_in,
    output ready_out
  );
endinterface

// File: rtl/stage5wb_q_fifo.sv
// wb_fifo: generic DEPTH x WIDTH circular buffer.
//   push/pop   : enqueue wdata / drop head (caller guarantees not full / not empty)
//   head       : oldest entry
//   count      : occupancy 0..DEPTH
//   entries    : all slots re-ordered by age, slot 0 = oldest
//   valid_mask : bit k set when age slot k holds a live entry
module wb_fifo
  import stage5wb_q_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [CNT_W-1:0]       count,
  output logic [DEPTH*WIDTH-1:0] entries,
  output logic [DEPTH-1:0]       valid_mask
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Age-ordered view of the buffer so consumers need not know the read pointer.
  always_comb begin
    entries    = '0;
    valid_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entries[k*WIDTH +: WIDTH] = mem_r[rd_ptr_r + PTR_W'(k)];
      valid_mask[k]             = (CNT_W'(k) < count_r);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/stage5wb_q.sv
// stage5wb_q: queued write-back stage.
//   up (slave)        : retiring entries from the RA stage (valid/ready)
//   rf_* / rf_grant   : arbitrated register-file write port
//   lr_* / flag_*     : link and flag register write strobes
//   fwd_*             : youngest-first lookup of uncommitted results
//   retire_valid, pc_out, instr_out : registered retirement report
//   count             : queue occupancy
module stage5wb_q
  import stage5wb_q_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  stage5wb_q_if.slave       up,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic              rf_grant,
  output logic [DATA_W-1:0] lr_wdata,
  output logic              lr_we,
  output logic [FLAG_W-1:0] flag_wdata,
  output logic              flag_we,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              retire_valid,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [CNT_W-1:0]  count
);

  localparam int ENTRY_W = entry_width(DATA_W, ADDR_W, FLAG_W);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic [ADDR_W-1:0] waddr;
    logic              reg_we;
    logic              lr_we;
    logic              flag_we;
  } entry_t;

  entry_t                   wr_entry_s;
  entry_t                   head_s;
  entry_t                   age_entry_s [DEPTH];
  logic [ENTRY_W-1:0]       head_raw_s;
  logic [DEPTH*ENTRY_W-1:0] entries_s;
  logic [DEPTH-1:0]         valid_mask_s;
  logic [CNT_W-1:0]         count_s;
  logic                     head_v_s;
  logic                     push_s;
  logic                     pop_s;

  // ready depends only on registered occupancy, never on rf_grant.
  assign up.ready_out = (count_s != CNT_W'(DEPTH));
  assign push_s       = up.valid_in && up.ready_out;
  assign head_v_s     = (count_s != CNT_W'(0));
  assign head_s       = entry_t'(head_raw_s);
  assign count        = count_s;

  assign wr_entry_s = '{pc:      up.pc_in,
                        instr:   up.instr_in,
                        result:  up.result_in,
                        flags:   up.flags_in,
                        waddr:   up.reg_waddr_in,
                        reg_we:  up.reg_we_in,
                        lr_we:   up.lr_we_in,
                        flag_we: up.flag_we_in};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .wdata      (wr_entry_s),
    .head       (head_raw_s),
    .count      (count_s),
    .entries    (entries_s),
    .valid_mask (valid_mask_s)
  );

  // Commit: an entry without an RF write leaves without waiting for a grant;
  // LR/flag strobes fire only in the popping cycle so each happens exactly once.
  always_comb begin
    rf_we      = head_v_s && head_s.reg_we;
    rf_waddr   = head_s.waddr;
    rf_wdata   = head_s.result;
    pop_s      = head_v_s && (!head_s.reg_we || rf_grant);
    lr_we      = pop_s && head_s.lr_we;
    lr_wdata   = head_s.result;
    flag_we    = pop_s && head_s.flag_we;
    flag_wdata = head_s.flags;
  end

  // Unpack the age-ordered slots (slot 0 oldest).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_entry_s[k] = entry_t'(entries_s[k*ENTRY_W +: ENTRY_W]);
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_mask_s[k] && age_entry_s[k].reg_we && (age_entry_s[k].waddr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = age_entry_s[k].result;
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end

  // Retirement report, one cycle after the pop; PC/instr hold between pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_valid <= 1'b0;
      pc_out       <= '0;
      instr_out    <= '0;
    end else begin
      retire_valid <= pop_s;
      if (pop_s) begin
        pc_out    <= head_s.pc;
        instr_out <= head_s.instr;
      end else begin
        pc_out    <= pc_out;
        instr_out <= instr_out;
      end
    end
  end

endmodule

// File: tb/tb_stage5wb_q.sv
// tb_stage5wb_q: directed bench for stage5wb_q with a queue-based reference model.
module tb_stage5wb_q;

  localparam int DW = 12;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] result;
    logic [FW-1:0] flags;
    logic [AW-1:0] waddr;
    logic          reg_we;
    logic          lr_we;
    logic          flag_we;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rf_grant = 1'b0;
  logic [AW-1:0] fwd_addr = 4'd0;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, lr_wdata, fwd_data, pc_out, instr_out;
  logic [FW-1:0] flag_wdata;
  logic          rf_we, lr_we, flag_we, fwd_hit, retire_valid;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  stage5wb_q_if #(.DATA_W(DW), .ADDR_W(AW), .FLAG_W(FW)) bus ();

  stage5wb_q #(.DATA_W(DW), .ADDR_W(AW), .FLAG_W(FW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .up(bus),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_grant(rf_grant),
    .lr_wdata(lr_wdata), .lr_we(lr_we), .flag_wdata(flag_wdata), .flag_we(flag_we),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_valid(retire_valid), .pc_out(pc_out), .instr_out(instr_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] instr,
                       input logic [DW-1:0] result, input logic [FW-1:0] flags,
                       input logic [AW-1:0] waddr, input logic rwe, input logic lwe,
                       input logic fwe);
    bus.valid_in     = v;
    bus.pc_in        = pc;
    bus.instr_in     = instr;
    bus.result_in    = result;
    bus.flags_in     = flags;
    bus.reg_waddr_in = waddr;
    bus.reg_we_in    = rwe;
    bus.lr_we_in     = lwe;
    bus.flag_we_in   = fwe;
  endtask

  // Reference model: an in-order queue plus the last retirement report.
  ent_t          q[$];
  logic          m_rv = 1'b0;
  logic [DW-1:0] m_pc = '0;
  logic [DW-1:0] m_instr = '0;

  // Compare every cycle at the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_rv    = 1'b0;
      m_pc    = '0;
      m_instr = '0;
    end else begin
      logic          has_head, e_rf, e_pop, e_hit, e_push;
      logic [DW-1:0] e_fwd;
      ent_t          h, inc;
      has_head = (q.size() > 0);
      h        = has_head ? q[0] : '0;
      e_rf     = has_head && h.reg_we;
      e_pop    = has_head && (!h.reg_we || rf_grant);
      e_hit    = 1'b0;
      e_fwd    = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].reg_we && q[i].waddr == fwd_addr) begin
          e_hit = 1'b1;
          e_fwd = q[i].result;
          break;
        end
      end
      check("count", 32'(count), 32'(q.size()));
      check("ready_out", 32'(bus.ready_out), 32'(q.size() < DEPTH));
      check("rf_we", 32'(rf_we), 32'(e_rf));
      if (e_rf) begin
        check("rf_waddr", 32'(rf_waddr), 32'(h.waddr));
        check("rf_wdata", 32'(rf_wdata), 32'(h.result));
      end
      check("lr_we", 32'(lr_we), 32'(e_pop && h.lr_we));
      if (e_pop && h.lr_we) check("lr_wdata", 32'(lr_wdata), 32'(h.result));
      check("flag_we", 32'(flag_we), 32'(e_pop && h.flag_we));
      if (e_pop && h.flag_we) check("flag_wdata", 32'(flag_wdata), 32'(h.flags));
      check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
      check("fwd_data", 32'(fwd_data), 32'(e_fwd));
      check("retire_valid", 32'(retire_valid), 32'(m_rv));
      check("pc_out", 32'(pc_out), 32'(m_pc));
      check("instr_out", 32'(instr_out), 32'(m_instr));
      // next state
      e_push = bus.valid_in && (q.size() < DEPTH);
      inc = '{pc: bus.pc_in, instr: bus.instr_in, result: bus.result_in, flags: bus.flags_in,
              waddr: bus.reg_waddr_in, reg_we: bus.reg_we_in, lr_we: bus.lr_we_in,
              flag_we: bus.flag_we_in};
      m_rv = e_pop;
      if (e_pop) begin
        m_pc    = h.pc;
        m_instr = h.instr;
        void'(q.pop_front());
      end
      if (e_push) q.push_back(inc);
    end
  end

  initial begin
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_retire_valid", 32'(retire_valid), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    tick();
    rst = 1'b0;

    // Single entry with grant held
    rf_grant = 1'b1;
    drive(1'b1, 12'h010, 12'h0A1, 12'hABC, 4'h5, 4'd3, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_rf_we", 32'(rf_we), 32'd1);
    check("t1_rf_waddr", 32'(rf_waddr), 32'd3);
    check("t1_rf_wdata", 32'(rf_wdata), 32'hABC);
    check("t1_flag_we", 32'(flag_we), 32'd1);
    check("t1_flag_wdata", 32'(flag_wdata), 32'h5);
    tick();
    @(negedge clk);
    check("t1_retire_valid", 32'(retire_valid), 32'd1);
    check("t1_pc_out", 32'(pc_out), 32'h010);

    // Backpressure: fill with grant low
    tick();
    rf_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'(12'h020 + i), 12'(12'h0B0 + i), 12'(12'h101 + i), 4'(i), 4'(i + 1),
            1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_ready_full", 32'(bus.ready_out), 32'd0);
    check("t2_rf_wdata", 32'(rf_wdata), 32'h101);
    tick();
    @(negedge clk);
    check("t2_rf_wdata_hold", 32'(rf_wdata), 32'h101);
    tick();
    rf_grant = 1'b1;
    drive(1'b1, 12'h030, 12'h0C0, 12'h130, 4'h0, 4'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_ready_full_pop", 32'(bus.ready_out), 32'd0);
    tick();
    @(negedge clk);
    check("t2_count_after_pop", 32'(count), 32'd3);
    check("t2_ready_after_pop", 32'(bus.ready_out), 32'd1);
    tick();
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("t2_drained", 32'(count), 32'd0);
    check("t2_last_pc", 32'(pc_out), 32'h030);

    // SRMOV leaves without a grant
    tick();
    rf_grant = 1'b0;
    drive(1'b1, 12'h040, 12'h0D0, 12'h123, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_lr_we", 32'(lr_we), 32'd1);
    check("t3_lr_wdata", 32'(lr_wdata), 32'h123);
    check("t3_rf_we", 32'(rf_we), 32'd0);
    tick();
    @(negedge clk);
    check("t3_retire", 32'(retire_valid), 32'd1);
    check("t3_pc_out", 32'(pc_out), 32'h040);

    // Forwarding, youngest first; incoming entry not visible
    tick();
    drive(1'b1, 12'h050, 12'h0E0, 12'h111, 4'h0, 4'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 12'h051, 12'h0E1, 12'h222, 4'h0, 4'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    fwd_addr = 4'd7;
    @(negedge clk);
    check("t4_hit7", 32'(fwd_hit), 32'd1);
    check("t4_data7", 32'(fwd_data), 32'h222);
    tick();
    fwd_addr = 4'd2;
    drive(1'b1, 12'h052, 12'h0E2, 12'h333, 4'h0, 4'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_hit2_incoming", 32'(fwd_hit), 32'd0);
    check("t4_data2_incoming", 32'(fwd_data), 32'h000);
    tick();
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_hit2_queued", 32'(fwd_hit), 32'd1);
    check("t4_data2_queued", 32'(fwd_data), 32'h333);
    tick();
    rf_grant = 1'b1;
    fwd_addr = 4'd7;
    tick();
    tick();
    tick();
    @(negedge clk);
    check("t4_drained", 32'(count), 32'd0);

    // Streaming with simultaneous push/pop, pointers wrap
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 12'(12'h100 + i), 12'(12'h300 + i), 12'(12'h200 + i), 4'(i), 4'(i),
            1'b1, 1'b0, 1'b0);
      if (i >= 1) begin
        @(negedge clk);
        check("t5_count_steady", 32'(count), 32'd1);
      end
      tick();
    end
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("t5_count_end", 32'(count), 32'd0);
    check("t5_last_pc", 32'(pc_out), 32'h109);
    check("t5_last_instr", 32'(instr_out), 32'h309);

    // Asynchronous reset with entries in flight
    tick();
    rf_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'(12'h060 + i), 12'(12'h0F0 + i), 12'(12'h400 + i), 4'hA, 4'(i + 8),
            1'b1, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 12'h000, 12'h000, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rf_grant = 1'b1;
    tick();
    #2;
    check("t6_pre_count", 32'(count), 32'd3);
    check("t6_pre_lr_we", 32'(lr_we), 32'd1);
    check("t6_pre_flag_we", 32'(flag_we), 32'd1);
    check("t6_pre_retire", 32'(retire_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_rf_we", 32'(rf_we), 32'd0);
    check("t6_rst_lr_we", 32'(lr_we), 32'd0);
    check("t6_rst_flag_we", 32'(flag_we), 32'd0);
    check("t6_rst_retire", 32'(retire_valid), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    rf_grant = 1'b0;
    @(negedge clk);
    check("t6_post_count", 32'(count), 32'd0);
    check("t6_post_ready", 32'(bus.ready_out), 32'd1);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

endmodule
